syncfifo_burst_drain: RTL and testbench

- Read-side companion to the sampled-output sync FIFO: pops words from the FIFO and presents them as a valid/ready burst stream.
- Word 0 of each burst is a header, which is consumed and held on a sideband; the following LEN+1 words are forwarded as data beats, with last asserted on the final beat.
- Sits between the NoC ingress FIFOs and the AXI-side packet consumers.

---
 rtl/syncfifo_burst_drain.sv | 120 ++++++++++++
 tb/tb_syncfifo_burst_drain.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syncfifo_burst_drain.sv
// Pops header+data bursts from a sampled-output FIFO into a valid/ready beat stream; DRAIN_STATS_EN adds burst/beat counters.
// Latency: data beat visible the cycle after its pop; backpressure via 2-entry skid, pops stop at occ=2 (never looks at ready).
module syncfifo_burst_drain #(
  parameter int WID  = 32,
  parameter int LENW = 8,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            softreset,
  input  logic            fifo_empty,
  input  logic [WID-1:0]  fifo_dout,
  output logic            fifo_readout,
  output logic            vldout,
  output logic [WID-1:0]  dout,
  output logic            last,
  input  logic            ready,
  output logic [TAGW-1:0] tag,
`ifdef DRAIN_STATS_EN
  output logic [15:0]     burst_cnt,
  output logic [31:0]     beat_cnt,
`endif
  output logic            busy
);

  typedef enum logic {IDLE, DATA} state_t;

  state_t                  state_q, state_d;
  logic [LENW-1:0]         rem_q, rem_d;
  logic [TAGW-1:0]         tag_q, tag_d;
  logic [1:0]              occ_q, occ_d;
  logic [1:0][WID-1:0]     skid_dat_q;
  logic [1:0]              skid_last_q;
  logic                    clr, pop, push, xfer, slot;

  assign clr = rst | softreset;

  // Pops are suppressed while reset is applied so no FIFO word is lost to a flush.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tag_d   = tag_q;
    pop     = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        pop = !fifo_empty && !clr;
        if (pop) begin
          tag_d   = fifo_dout[LENW+TAGW-1:LENW];
          rem_d   = fifo_dout[LENW-1:0];
          state_d = DATA;
        end
      end
      DATA: begin
        pop  = !fifo_empty && (occ_q < 2'd2) && !clr;
        push = pop;
        if (pop) begin
          if (rem_q == '0) state_d = IDLE;
          else             rem_d   = rem_q - LENW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_readout = pop;
  assign vldout       = (occ_q != 2'd0);
  assign dout         = skid_dat_q[0];
  assign last         = vldout && skid_last_q[0];
  assign tag          = tag_q;
  assign busy         = (state_q == DATA) || (occ_q != 2'd0);
  assign xfer         = vldout && ready;
  assign occ_d        = occ_q + 2'(push) - 2'(xfer);
  // Write slot is the first free entry after any head shift this cycle.
  assign slot         = xfer ? (occ_q == 2'd2) : (occ_q == 2'd1);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tag_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tag_q   <= tag_d;
      occ_q   <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      skid_dat_q[0]  <= skid_dat_q[1];
      skid_last_q[0] <= skid_last_q[1];
    end
    if (push) begin
      skid_dat_q[slot]  <= fifo_dout;
      skid_last_q[slot] <= (rem_q == '0);
    end
  end

`ifdef DRAIN_STATS_EN
  logic [15:0] burst_cnt_q;
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      burst_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else if (xfer) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (last) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign burst_cnt = burst_cnt_q;
  assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_syncfifo_burst_drain.sv
// Directed bench for syncfifo_burst_drain with a behavioural FIFO in front and a beat recorder behind.
module tb_syncfifo_burst_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        softreset = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_readout;
  logic        vldout;
  logic [31:0] dout;
  logic        last;
  logic        ready = 1'b0;
  logic [7:0]  tag;
  logic        busy;
`ifdef DRAIN_STATS_EN
  logic [15:0] burst_cnt;
  logic [31:0] beat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  logic [5:0]  rd_ptr = 6'd0;
  logic [5:0]  wr_ptr = 6'd0;

  int          cyc = 0;
  int          nbeats = 0;
  int          npops = 0;
  logic [31:0] beat_dat  [64];
  logic        beat_last [64];
  logic [7:0]  beat_tag  [64];
  int          beat_cyc  [64];

  syncfifo_burst_drain dut (
    .clk          (clk),
    .rst          (rst),
    .softreset    (softreset),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_readout (fifo_readout),
    .vldout       (vldout),
    .dout         (dout),
    .last         (last),
    .ready        (ready),
    .tag          (tag),
`ifdef DRAIN_STATS_EN
    .burst_cnt    (burst_cnt),
    .beat_cnt     (beat_cnt),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = mem[rd_ptr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_readout && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 6'd1;
  end

  // Inputs only change at posedge+1, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (vldout && ready && nbeats < 64) begin
      beat_dat[nbeats]  = dout;
      beat_last[nbeats] = last;
      beat_tag[nbeats]  = tag;
      beat_cyc[nbeats]  = cyc;
      nbeats = nbeats + 1;
    end
    if (fifo_readout) npops = npops + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic start_scenario();
    tick();
    nbeats = 0;
    npops  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (vldout !== 1'b0) begin errors++; $display("FAIL reset_vldout got %b want 0", vldout); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last); end
    checks++; if (tag !== 8'h00) begin errors++; $display("FAIL reset_tag got %h want 00", tag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fifo_readout !== 1'b0) begin errors++; $display("FAIL reset_readout got %b want 0", fifo_readout); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    int to;
    start_scenario();
    ready = 1'b1;
    push_word(32'h0000_0500);
    push_word(32'hAAAA_0001);
    to = 0;
    while (nbeats < 1 && to < 50) begin tick(); to++; end
    checks++; if (to >= 50) begin errors++; $display("FAIL single_timeout got %0d beats want 1", nbeats); end
    repeat (3) tick();
    @(negedge clk);
    checks++; if (nbeats !== 1) begin errors++; $display("FAIL single_count got %0d want 1", nbeats); end
    checks++; if (beat_dat[0] !== 32'hAAAA_0001) begin errors++; $display("FAIL single_dout got %h want aaaa0001", beat_dat[0]); end
    checks++; if (beat_last[0] !== 1'b1) begin errors++; $display("FAIL single_last got %b want 1", beat_last[0]); end
    checks++; if (beat_tag[0] !== 8'h05) begin errors++; $display("FAIL single_tag got %h want 05", beat_tag[0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy); end
    checks++; if (npops !== 2) begin errors++; $display("FAIL single_pops got %0d want 2", npops); end
  endtask

  task automatic test_four_beat();
    int to;
    start_scenario();
    ready = 1'b1;
    push_word(32'h0000_0703);
    for (int i = 0; i < 4; i++) push_word(32'h10 + i);
    to = 0;
    while (nbeats < 4 && to < 50) begin tick(); to++; end
    checks++; if (to >= 50) begin errors++; $display("FAIL four_timeout got %0d beats want 4", nbeats); end
    repeat (3) tick();
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL four_count got %0d want 4", nbeats); end
    checks++; if (npops !== 5) begin errors++; $display("FAIL four_pops got %0d want 5", npops); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (beat_dat[i] !== 32'h10 + i) begin errors++; $display("FAIL four_dout[%0d] got %h want %h", i, beat_dat[i], 32'h10 + i); end
      checks++;
      if (beat_last[i] !== (i == 3)) begin errors++; $display("FAIL four_last[%0d] got %b want %b", i, beat_last[i], (i == 3)); end
      checks++;
      if (beat_cyc[i] !== beat_cyc[0] + i) begin errors++; $display("FAIL four_consecutive[%0d] got cyc %0d want %0d", i, beat_cyc[i], beat_cyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    int to;
    logic [31:0] held_dat;
    logic        held_last;
    start_scenario();
    ready = 1'b1;
    push_word(32'h0000_0307);
    for (int i = 0; i < 8; i++) push_word(32'h20 + i);
    to = 0;
    while (nbeats < 2 && to < 50) begin tick(); to++; end
    checks++; if (to >= 50) begin errors++; $display("FAIL bp_timeout_pre got %0d beats want 2", nbeats); end
    ready = 1'b0;
    held_dat  = 32'h0;
    held_last = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s == 0) begin
        held_dat  = dout;
        held_last = last;
        checks++; if (dout !== 32'h22) begin errors++; $display("FAIL bp_stall_head got %h want 00000022", dout); end
      end else begin
        checks++; if (dout !== held_dat) begin errors++; $display("FAIL bp_dout_stable[%0d] got %h want %h", s, dout, held_dat); end
        checks++; if (last !== held_last) begin errors++; $display("FAIL bp_last_stable[%0d] got %b want %b", s, last, held_last); end
        checks++; if (vldout !== 1'b1) begin errors++; $display("FAIL bp_vld_stall[%0d] got %b want 1", s, vldout); end
        checks++; if (fifo_readout !== 1'b0) begin errors++; $display("FAIL bp_readout_full[%0d] got %b want 0", s, fifo_readout); end
      end
      tick();
    end
    ready = 1'b1;
    to = 0;
    while (nbeats < 8 && to < 50) begin tick(); to++; end
    checks++; if (to >= 50) begin errors++; $display("FAIL bp_timeout_post got %0d beats want 8", nbeats); end
    repeat (3) tick();
    checks++; if (nbeats !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", nbeats); end
    checks++; if (npops !== 9) begin errors++; $display("FAIL bp_pops got %0d want 9", npops); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (beat_dat[i] !== 32'h20 + i) begin errors++; $display("FAIL bp_dout[%0d] got %h want %h", i, beat_dat[i], 32'h20 + i); end
      checks++;
      if (beat_last[i] !== (i == 7)) begin errors++; $display("FAIL bp_last[%0d] got %b want %b", i, beat_last[i], (i == 7)); end
    end
  endtask

  task automatic test_back_to_back();
    int to;
    logic [31:0] exp_dat [5];
    logic        exp_last [5];
    int          exp_off [5];
    exp_dat  = '{32'hD0, 32'hD1, 32'hE0, 32'hE1, 32'hE2};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_off  = '{0, 1, 3, 4, 5};
    start_scenario();
    ready = 1'b1;
    push_word(32'h0000_0101);
    push_word(32'hD0);
    push_word(32'hD1);
    push_word(32'h0000_0202);
    push_word(32'hE0);
    push_word(32'hE1);
    push_word(32'hE2);
    to = 0;
    while (nbeats < 5 && to < 50) begin tick(); to++; end
    checks++; if (to >= 50) begin errors++; $display("FAIL b2b_timeout got %0d beats want 5", nbeats); end
    repeat (3) tick();
    checks++; if (nbeats !== 5) begin errors++; $display("FAIL b2b_count got %0d want 5", nbeats); end
    checks++; if (npops !== 7) begin errors++; $display("FAIL b2b_pops got %0d want 7", npops); end
    checks++; if (beat_tag[0] !== 8'h01) begin errors++; $display("FAIL b2b_tag_first got %h want 01", beat_tag[0]); end
    checks++; if (beat_tag[2] !== 8'h02) begin errors++; $display("FAIL b2b_tag_e0 got %h want 02", beat_tag[2]); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (beat_dat[i] !== exp_dat[i]) begin errors++; $display("FAIL b2b_dout[%0d] got %h want %h", i, beat_dat[i], exp_dat[i]); end
      checks++;
      if (beat_last[i] !== exp_last[i]) begin errors++; $display("FAIL b2b_last[%0d] got %b want %b", i, beat_last[i], exp_last[i]); end
      checks++;
      if (beat_cyc[i] !== beat_cyc[0] + exp_off[i]) begin errors++; $display("FAIL b2b_timing[%0d] got cyc %0d want %0d", i, beat_cyc[i], beat_cyc[0] + exp_off[i]); end
    end
  endtask

  task automatic test_softreset();
    int to;
    start_scenario();
    ready = 1'b1;
    push_word(32'h0000_0107);
    for (int i = 0; i < 8; i++) push_word(32'h0000_9000 + i);
    to = 0;
    while (nbeats < 2 && to < 50) begin tick(); to++; end
    checks++; if (to >= 50) begin errors++; $display("FAIL srst_timeout_pre got %0d beats want 2", nbeats); end
    softreset = 1'b1;
    ready     = 1'b0;
    tick();
    softreset = 1'b0;
    @(negedge clk);
    checks++; if (vldout !== 1'b0) begin errors++; $display("FAIL srst_vldout got %b want 0", vldout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL srst_busy got %b want 0", busy); end
    checks++; if (fifo_readout !== 1'b1) begin errors++; $display("FAIL srst_header_pop got %b want 1", fifo_readout); end
    checks++; if (fifo_dout !== 32'h0000_9003) begin errors++; $display("FAIL srst_next_word got %h want 00009003", fifo_dout); end
    tick();
    ready = 1'b1;
    to = 0;
    while (nbeats < 6 && to < 50) begin tick(); to++; end
    checks++; if (to >= 50) begin errors++; $display("FAIL srst_timeout_post got %0d beats want 6", nbeats); end
    repeat (3) tick();
    checks++; if (nbeats !== 6) begin errors++; $display("FAIL srst_count got %0d want 6", nbeats); end
    checks++; if (beat_dat[1] !== 32'h0000_9001) begin errors++; $display("FAIL srst_pre_dout got %h want 00009001", beat_dat[1]); end
    for (int i = 2; i < 6; i++) begin
      checks++;
      if (beat_dat[i] !== 32'h0000_9002 + i) begin errors++; $display("FAIL srst_dout[%0d] got %h want %h", i, beat_dat[i], 32'h0000_9002 + i); end
      checks++;
      if (beat_last[i] !== (i == 5)) begin errors++; $display("FAIL srst_last[%0d] got %b want %b", i, beat_last[i], (i == 5)); end
      checks++;
      if (beat_tag[i] !== 8'h90) begin errors++; $display("FAIL srst_tag[%0d] got %h want 90", i, beat_tag[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL srst_busy_end got %b want 0", busy); end
  endtask

`ifdef DRAIN_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (burst_cnt !== 16'd0) begin errors++; $display("FAIL stats_burst_reset got %0d want 0", burst_cnt); end
    checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL stats_beat_reset got %0d want 0", beat_cnt); end
    test_back_to_back();
    @(negedge clk);
    checks++; if (burst_cnt !== 16'd2) begin errors++; $display("FAIL stats_burst got %0d want 2", burst_cnt); end
    checks++; if (beat_cnt !== 32'd5) begin errors++; $display("FAIL stats_beat got %0d want 5", beat_cnt); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (burst_cnt !== 16'd0) begin errors++; $display("FAIL stats_burst_clear got %0d want 0", burst_cnt); end
    checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL stats_beat_clear got %0d want 0", beat_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_four_beat();
    test_backpressure();
    test_back_to_back();
    test_softreset();
`ifdef DRAIN_STATS_EN
    test_stats();
`endif
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
